// File: rtl/mult32x32_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package mult32x32_pkg;

  localparam int unsigned OP_W     = 32;
  localparam int unsigned PROD_W   = 64;
  localparam int unsigned FAST_LAT = 4;
  localparam int unsigned FULL_LAT = 7;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclic.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  logic [IDW-1:0] idx;

  function automatic logic [IDW-1:0] wrap(input int unsigned v);
    return IDW'(v % N);
  endfunction

  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = wrap(32'(ptr) + k);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_id    = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult32x32_arbiter.sv
// Round-robin sequencer sharing one mult32x32_fast between N requesters,
// with a watchdog on the multiplier busy handshake.
module mult32x32_arbiter
  import mult32x32_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IDW  = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned WDOG = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_valid,
  input  logic [N*OP_W-1:0]   req_a,
  input  logic [N*OP_W-1:0]   req_b,
  output logic [N-1:0]        req_ready,
  output logic [N-1:0]        rsp_valid,
  output logic [PROD_W-1:0]   rsp_product,
  output logic [IDW-1:0]      rsp_id,
  output logic                mult_start,
  output logic [OP_W-1:0]     mult_a,
  output logic [OP_W-1:0]     mult_b,
  input  logic                mult_busy,
  input  logic [PROD_W-1:0]   mult_product,
  output logic                err
);

  localparam int unsigned WDW = $clog2(WDOG + 1);

  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              err_q, err_d;
  logic [WDW-1:0]    wdog_q, wdog_d;

  logic [N-1:0]      pick_gnt;
  logic [IDW-1:0]    pick_id;
  logic              pick_vld;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (pick_gnt),
    .gnt_id    (pick_id),
    .gnt_valid (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    err_d       = err_q;
    wdog_d      = '0;
    req_ready   = '0;
    rsp_valid   = '0;
    mult_start  = 1'b0;
    rsp_product = prod_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          req_ready = pick_gnt;
          for (int unsigned i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
              a_d = req_a[OP_W*i +: OP_W];
              b_d = req_b[OP_W*i +: OP_W];
            end
          end
          id_d    = pick_id;
          ptr_d   = (pick_id == IDW'(N - 1)) ? '0 : pick_id + 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        mult_start = 1'b1;
        state_d    = WAIT_HI;
      end
      WAIT_HI, WAIT_LO: begin
        // WAIT_HI waits for busy to rise, WAIT_LO for it to fall.
        if ((state_q == WAIT_HI) == mult_busy) begin
          state_d = (state_q == WAIT_HI) ? WAIT_LO : RESP;
        end else if (wdog_q == WDW'(WDOG - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rsp_product     = mult_product;
        prod_d          = mult_product;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign rsp_id = id_q;
  assign mult_a = a_q;
  assign mult_b = b_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Bench for mult32x32_arbiter: directed cases then randomized traffic against
// a round-robin/arithmetic reference model and a behavioural multiplier.
module tb_mult32x32_arbiter;
  import mult32x32_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned WDOG = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [63:0]     rsp_product;
  logic [IDW-1:0]  rsp_id;
  logic            mult_start;
  logic [31:0]     mult_a, mult_b;
  logic            mult_busy;
  logic [63:0]     mult_product;
  logic            err;

  mult32x32_arbiter #(
    .N    (N),
    .IDW  (IDW),
    .WDOG (WDOG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_product  (rsp_product),
    .rsp_id       (rsp_id),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: busy 1 cycle on the fast path, 4 otherwise.
  logic stall = 1'b0;
  int   busy_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt     <= 0;
      mult_product <= '0;
    end else if (mult_start && !stall) begin
      busy_cnt     <= (mult_a[31:16] == 16'h0 && mult_b[31:16] == 16'h0) ? 1 : 4;
      mult_product <= {32'h0, mult_a} * {32'h0, mult_b};
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign mult_busy = (busy_cnt != 0);

  int n_start = 0;
  int n_rsp = 0;
  always @(negedge clk) begin
    if (mult_start) n_start++;
    if (rsp_valid != '0) n_rsp++;
  end

  int          n_err = 0;
  int          n_chk = 0;
  int          ptr = 0;
  logic        exp_err = 1'b0;
  logic [N-1:0] pend = '0;
  logic [31:0] opa [N];
  logic [31:0] opb [N];
  logic [63:0] last_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  task automatic apply();
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = opa[i];
      req_b[32*i +: 32] = opb[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend  = '0;
    apply();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    ptr     = 0;
    exp_err = 1'b0;
  endtask

  // Called one step after a rising edge in an IDLE cycle with pend applied.
  task automatic do_op();
    int g, w, lat, nrdy, s0;
    int unsigned exp_lat;
    logic [63:0] exp_p;
    g = pick(pend, ptr);
    w = 0;
    do begin @(negedge clk); w++; end while (req_ready == '0 && w < 20);
    check($sformatf("grant_%0d", g), 64'(req_ready), 64'd1 << g);
    check("grant_gap", 64'(w), 64'd1);
    exp_p   = ref_mul(opa[g], opb[g]);
    exp_lat = (opa[g] < 32'h1_0000 && opb[g] < 32'h1_0000) ? FAST_LAT : FULL_LAT;
    s0 = n_start; nrdy = 0; lat = 0;
    @(posedge clk); #1;
    pend[g] = 1'b0;
    apply();
    do begin
      @(negedge clk);
      lat++;
      if (req_ready != '0) nrdy++;
    end while (rsp_valid == '0 && lat < 40);
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_valid", 64'(rsp_valid), 64'd1 << g);
    check("rsp_id", 64'(rsp_id), 64'(g));
    check("product", rsp_product, exp_p);
    check("one_start", 64'(n_start - s0), 64'd1);
    check("no_ready_busy", 64'(nrdy), 64'd0);
    check("err", 64'(err), 64'(exp_err));
    ptr    = (g + 1) % N;
    last_p = exp_p;
  endtask

  initial begin
    int s0, r0, w;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end

    // Reset and idle
    do_reset();
    s0 = n_start;
    repeat (20) @(negedge clk);
    check("idle_no_start", 64'(n_start - s0), 64'd0);
    check("idle_ready", 64'(req_ready), 64'd0);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_product", rsp_product, 64'd0);
    check("idle_id", 64'(rsp_id), 64'd0);
    check("idle_mult_ab", {mult_a, mult_b}, 64'd0);
    check("idle_err", 64'(err), 64'd0);

    // Requester 2, fast path
    @(posedge clk); #1;
    opa[2] = 32'h3; opb[2] = 32'h5; pend = 4'b0100; apply();
    do_op();
    check("p_3x5", rsp_product, 64'hF);
    @(negedge clk);
    check("hold_product", rsp_product, 64'hF);
    check("hold_rsp_valid", 64'(rsp_valid), 64'd0);
    check("hold_mult_a", 64'(mult_a), 64'h3);

    // Requester 0, full path
    @(posedge clk); #1;
    opa[0] = 32'hFFFF_FFFF; opb[0] = 32'hFFFF_FFFF; pend = 4'b0001; apply();
    do_op();
    check("p_max", rsp_product, 64'hFFFF_FFFE_0000_0001);

    // All four continuously, each re-requesting after its response
    do_reset();
    for (int i = 0; i < N; i++) begin opa[i] = 32'(i + 1); opb[i] = 32'h0001_0000; end
    pend = '1; apply();
    for (int k = 0; k < 5; k++) begin
      do_op();
      check($sformatf("order_%0d", k), 64'(rsp_id), 64'(k % N));
      check($sformatf("p_shift_%0d", k), rsp_product, 64'(k % N + 1) << 16);
      @(posedge clk); #1;
      if (k < 4) pend[k % N] = 1'b1;
      apply();
    end
    for (int k = 0; k < 3; k++) begin
      do_op();
      @(posedge clk); #1;
    end

    // Reset while in WAIT_LO aborts the operation silently
    opa[2] = 32'h1234_5678; opb[2] = 32'h9ABC_DEF0; pend = 4'b0100; apply();
    w = 0;
    do begin @(negedge clk); w++; end while (req_ready == '0 && w < 20);
    check("abort_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1; pend = '0; apply();
    @(posedge clk); #1;
    @(posedge clk); #1;
    r0 = n_rsp;
    do_reset();
    repeat (10) @(negedge clk);
    check("abort_no_rsp", 64'(n_rsp - r0), 64'd0);
    check("abort_product", rsp_product, 64'd0);
    @(posedge clk); #1;
    opa[1] = 32'h0000_ABCD; opb[1] = 32'h0000_0100;
    opa[3] = 32'h8000_0000; opb[3] = 32'h0000_0002;
    pend = 4'b1010; apply();
    do_op();
    check("ptr_after_reset", 64'(rsp_id), 64'd1);
    @(posedge clk); #1;
    do_op();

    // Multiplier never raises busy: watchdog trips
    @(posedge clk); #1;
    stall = 1'b1;
    opa[2] = 32'd7; opb[2] = 32'd9; pend = 4'b0100; apply();
    w = 0;
    do begin @(negedge clk); w++; end while (req_ready == '0 && w < 20);
    check("wd_grant", 64'(req_ready), 64'b0100);
    s0 = n_start; r0 = n_rsp;
    @(posedge clk); #1; pend = '0; apply();
    repeat (WDOG - 1) @(negedge clk);
    check("wd_err_early", 64'(err), 64'd0);
    w = 0;
    while (!err && w < 10) begin @(negedge clk); w++; end
    check("wd_err_set", 64'(err), 64'd1);
    check("wd_no_rsp", 64'(n_rsp - r0), 64'd0);
    check("wd_one_start", 64'(n_start - s0), 64'd1);
    ptr = 3; exp_err = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    opa[3] = 32'd11; opb[3] = 32'd13; pend = 4'b1000; apply();
    do_op();

    // Randomized traffic
    do_reset();
    check("err_cleared", 64'(err), 64'd0);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          opa[i]  = $urandom;
          opb[i]  = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            opa[i] = opa[i] & 32'h0000_FFFF;
            opb[i] = opb[i] & 32'h0000_FFFF;
          end
        end
      end
      if (pend == '0) begin
        w = int'($urandom_range(0, N - 1));
        pend[w] = 1'b1;
        opa[w]  = $urandom;
        opb[w]  = $urandom;
      end
      apply();
      do_op();
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "timeout");
  end

endmodule
